// File: rtl/light_pkg.sv
// Shared types, default constants and saturating helpers for the
// ambient-light PWM driver.
package light_pkg;

  typedef enum logic [1:0] {
    DARK   = 2'd0,
    DIM    = 2'd1,
    BRIGHT = 2'd2
  } level_t;

  localparam int DEF_TH_LO       = 120;
  localparam int DEF_TH_HI       = 170;
  localparam int DEF_HYST        = 8;
  localparam int DEF_DUTY_DARK   = 1600;
  localparam int DEF_DUTY_DIM    = 800;
  localparam int DEF_DUTY_BRIGHT = 200;

  // a + b, clipped to max_val
  function automatic int sat_add(input int a, input int b, input int max_val);
    int s;
    s = a + b;
    if (s > max_val) return max_val;
    return s;
  endfunction

  // a - b, clipped to 0
  function automatic int sat_sub(input int a, input int b);
    if (b > a) return 0;
    return a - b;
  endfunction

endpackage

// File: rtl/light_level_fsm.sv
// Hysteresis classifier: maps the light level to DARK/DIM/BRIGHT,
// re-evaluated only when SAMPLE pulses.
module light_level_fsm
  import light_pkg::*;
#(
  parameter int LIGHT_W = 8,
  parameter int TH_LO   = DEF_TH_LO,
  parameter int TH_HI   = DEF_TH_HI,
  parameter int HYST    = DEF_HYST
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SAMPLE,
  input  logic [LIGHT_W-1:0] LIGHT,
  output level_t             LEVEL
);

  localparam int LIGHT_MAX = (2 ** LIGHT_W) - 1;
  // Switching points, saturated to the LIGHT range
  localparam logic [LIGHT_W-1:0] LO_UP = LIGHT_W'(sat_add(TH_LO, HYST, LIGHT_MAX));
  localparam logic [LIGHT_W-1:0] LO_DN = LIGHT_W'(sat_sub(TH_LO, HYST));
  localparam logic [LIGHT_W-1:0] HI_UP = LIGHT_W'(sat_add(TH_HI, HYST, LIGHT_MAX));
  localparam logic [LIGHT_W-1:0] HI_DN = LIGHT_W'(sat_sub(TH_HI, HYST));

  level_t state_reg, state_next;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= DARK;
    else     state_reg <= state_next;
  end

  // Next-state: only moves on a sample tick; direct jumps skip DIM
  always_comb begin
    state_next = state_reg;
    if (SAMPLE) begin
      case (state_reg)
        DARK: begin
          if (LIGHT >= HI_UP)     state_next = BRIGHT;
          else if (LIGHT > LO_UP) state_next = DIM;
        end
        DIM: begin
          if (LIGHT <= LO_DN)      state_next = DARK;
          else if (LIGHT >= HI_UP) state_next = BRIGHT;
        end
        BRIGHT: begin
          if (LIGHT <= LO_DN)     state_next = DARK;
          else if (LIGHT < HI_DN) state_next = DIM;
        end
        default: state_next = DARK;
      endcase
    end
  end

  // Output: current class
  always_comb begin
    LEVEL = state_reg;
  end

endmodule

// File: rtl/light_pwm_array.sv
// Ambient-light controlled multi-channel LED PWM with soft duty ramping
// and staggered channel phases.
// Optional manual duty override: define LIGHT_PWM_MANUAL_EN.
module light_pwm_array
  import light_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int LIGHT_W     = 8,
  parameter int CNT_W       = 12,
  parameter int PERIOD      = 2000,
  parameter int DIV_TICK    = 500,
  parameter int SAMPLE_DIV  = 2000,
  parameter int TH_LO       = DEF_TH_LO,
  parameter int TH_HI       = DEF_TH_HI,
  parameter int HYST        = DEF_HYST,
  parameter int DUTY_DARK   = DEF_DUTY_DARK,
  parameter int DUTY_DIM    = DEF_DUTY_DIM,
  parameter int DUTY_BRIGHT = DEF_DUTY_BRIGHT,
  parameter int RAMP_STEP   = 50
) (
  input  logic               CLK,
  input  logic               RST,
`ifdef LIGHT_PWM_MANUAL_EN
  input  logic               MAN,
  input  logic [CNT_W-1:0]   MAN_DUTY,
`endif
  input  logic [N_CH-1:0]    EN,
  input  logic [LIGHT_W-1:0] LIGHT,
  output logic [N_CH-1:0]    LED,
  output logic [1:0]         LEVEL,
  output logic [CNT_W-1:0]   DUTY
);

  localparam int PW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV_TICK - 1);
  localparam logic [SW-1:0]    SAMP_LAST  = SW'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PERIOD_C   = CNT_W'(PERIOD);
  localparam logic [CNT_W:0]   PERIOD_X   = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(RAMP_STEP);

  logic [PW-1:0]    presc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [SW-1:0]    samp_reg;
  logic [CNT_W-1:0] duty_reg, duty_next;
  logic [CNT_W-1:0] target, target_lvl;
  logic [N_CH-1:0]  led_reg, led_next;
  logic             step_tick, period_end, sample_tick;
  level_t           level;

  assign step_tick   = (presc_reg == PRESC_LAST);
  assign period_end  = step_tick && (cnt_reg == CNT_LAST);
  assign sample_tick = step_tick && (samp_reg == SAMP_LAST);

  // Prescaler, PWM counter and sample counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
      samp_reg  <= '0;
    end else begin
      presc_reg <= step_tick ? '0 : presc_reg + 1'b1;
      if (step_tick) begin
        cnt_reg  <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        samp_reg <= (samp_reg == SAMP_LAST) ? '0 : samp_reg + 1'b1;
      end
    end
  end

  light_level_fsm #(
    .LIGHT_W (LIGHT_W),
    .TH_LO   (TH_LO),
    .TH_HI   (TH_HI),
    .HYST    (HYST)
  ) u_fsm (
    .CLK    (CLK),
    .RST    (RST),
    .SAMPLE (sample_tick),
    .LIGHT  (LIGHT),
    .LEVEL  (level)
  );

  // Target duty follows the registered level, so a boundary coinciding with
  // a sample still ramps toward the pre-sample target
  always_comb begin
    case (level)
      DIM:     target_lvl = CNT_W'(DUTY_DIM);
      BRIGHT:  target_lvl = CNT_W'(DUTY_BRIGHT);
      default: target_lvl = CNT_W'(DUTY_DARK);
    endcase
  end

`ifdef LIGHT_PWM_MANUAL_EN
  assign target = MAN ? ((MAN_DUTY > PERIOD_C) ? PERIOD_C : MAN_DUTY) : target_lvl;
`else
  assign target = target_lvl;
`endif

  // Bounded step toward the target
  always_comb begin
    duty_next = duty_reg;
    if (target > duty_reg)
      duty_next = ((target - duty_reg) > STEP_C) ? duty_reg + STEP_C : target;
    else if (target < duty_reg)
      duty_next = ((duty_reg - target) > STEP_C) ? duty_reg - STEP_C : target;
  end

  // Duty only changes at period boundaries so no pulse is cut short
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             duty_reg <= '0;
    else if (period_end) duty_reg <= duty_next;
  end

  // Per-channel phase-shifted comparators
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [CNT_W:0] OFF = (CNT_W + 1)'((PERIOD * gi) / N_CH);
    logic [CNT_W:0] sum;
    logic [CNT_W:0] ph;
    assign sum          = {1'b0, cnt_reg} + OFF;
    assign ph           = (sum >= PERIOD_X) ? sum - PERIOD_X : sum;
    assign led_next[gi] = EN[gi] & (ph < {1'b0, duty_reg});
  end

  // Registered LED outputs, cleared immediately by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) led_reg <= '0;
    else     led_reg <= led_next;
  end

  assign LED   = led_reg;
  assign LEVEL = level;
  assign DUTY  = duty_reg;

endmodule

// File: tb/tb_light_pwm_array.sv
// Directed self-checking bench for light_pwm_array (small parameter set:
// DIV_TICK=2, PERIOD=20, SAMPLE_DIV=20, N_CH=4, duties 16/8/2, RAMP_STEP=4).
// Build with LIGHT_PWM_MANUAL_EN defined to also exercise the manual override.
module tb_light_pwm_array;

  logic        CLK;
  logic        RST;
  logic [3:0]  EN;
  logic [7:0]  LIGHT;
  logic [3:0]  LED;
  logic [1:0]  LEVEL;
  logic [11:0] DUTY;
`ifdef LIGHT_PWM_MANUAL_EN
  logic        MAN;
  logic [11:0] MAN_DUTY;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;  // rising edges since reset release

  light_pwm_array #(
    .N_CH(4), .LIGHT_W(8), .CNT_W(12), .PERIOD(20), .DIV_TICK(2),
    .SAMPLE_DIV(20), .TH_LO(120), .TH_HI(170), .HYST(8),
    .DUTY_DARK(16), .DUTY_DIM(8), .DUTY_BRIGHT(2), .RAMP_STEP(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
`ifdef LIGHT_PWM_MANUAL_EN
    .MAN      (MAN),
    .MAN_DUTY (MAN_DUTY),
`endif
    .EN       (EN),
    .LIGHT    (LIGHT),
    .LED      (LED),
    .LEVEL    (LEVEL),
    .DUTY     (DUTY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance to edge e, sampling 1 time unit after it
  task automatic run_to(input int e);
    while (ecnt < e) begin
      @(posedge CLK);
      ecnt++;
      #1;
    end
  endtask

  // Spec-level LED pattern after edge e: counter value is (e-1)/2 mod 20,
  // channel offset 5*i step ticks
  function automatic logic [3:0] exp_led(input int e, input int duty, input logic [3:0] en);
    logic [3:0] r;
    int c;
    c = ((e - 1) / 2) % 20;
    for (int i = 0; i < 4; i++) r[i] = en[i] && (((c + 5 * i) % 20) < duty);
    return r;
  endfunction

  task automatic test_reset;
    RST = 1'b1; EN = 4'hF; LIGHT = 8'd50;
`ifdef LIGHT_PWM_MANUAL_EN
    MAN = 1'b0; MAN_DUTY = 12'd0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (LED !== 4'h0) begin n_bad++; $display("FAIL reset_led: got %h expected 0", LED); end
    n_cmp++; if (DUTY !== 12'd0) begin n_bad++; $display("FAIL reset_duty: got %0d expected 0", DUTY); end
    n_cmp++; if (LEVEL !== 2'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", LEVEL); end
    @(negedge CLK);
    RST = 1'b0;
    ecnt = 0;
    $display("test_reset done");
  endtask

  task automatic test_ramp_up;
    for (int k = 1; k <= 4; k++) begin
      run_to(40 * k - 1);
      n_cmp++;
      if (DUTY !== 12'(4 * (k - 1))) begin
        n_bad++; $display("FAIL ramp_pre_%0d: got %0d expected %0d", k, DUTY, 4 * (k - 1));
      end
      run_to(40 * k);
      n_cmp++;
      if (DUTY !== 12'(4 * k)) begin
        n_bad++; $display("FAIL ramp_post_%0d: got %0d expected %0d", k, DUTY, 4 * k);
      end
    end
    n_cmp++; if (LEVEL !== 2'd0) begin n_bad++; $display("FAIL ramp_level: got %0d expected 0", LEVEL); end
    $display("test_ramp_up done at edge %0d, DUTY=%0d", ecnt, DUTY);
  endtask

  // One full period at DUTY=16: 32 high cycles each, rise edges staggered
  task automatic test_phase;
    int hi [4];
    int rise [4];
    int exp_rise [4];
    logic [3:0] prev;
    exp_rise = '{1, 31, 21, 11};
    for (int i = 0; i < 4; i++) begin hi[i] = 0; rise[i] = -1; end
    prev = LED;
    for (int e = 161; e <= 200; e++) begin
      run_to(e);
      for (int i = 0; i < 4; i++) begin
        if (LED[i]) hi[i]++;
        if (LED[i] && !prev[i]) rise[i] = e % 40;
      end
      prev = LED;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hi[i] != 32) begin n_bad++; $display("FAIL phase_high_ch%0d: got %0d expected 32", i, hi[i]); end
      n_cmp++;
      if (rise[i] != exp_rise[i]) begin
        n_bad++; $display("FAIL phase_rise_ch%0d: got %0d expected %0d", i, rise[i], exp_rise[i]);
      end
    end
    $display("test_phase done");
  endtask

  task automatic test_enable;
    int bad2;
    int bad_other;
    logic [3:0] exp;
    n_cmp++; if (LED[2] !== 1'b1) begin n_bad++; $display("FAIL en_pre: got %b expected 1", LED[2]); end
    EN = 4'b1011;
    run_to(201);
    n_cmp++; if (LED[2] !== 1'b0) begin n_bad++; $display("FAIL en_drop: got %b expected 0", LED[2]); end
    exp = exp_led(201, 16, 4'hF) & 4'b1011;
    n_cmp++;
    if ((LED & 4'b1011) !== exp) begin n_bad++; $display("FAIL en_others: got %b expected %b", LED & 4'b1011, exp); end
    bad2 = 0; bad_other = 0;
    for (int e = 202; e <= 260; e++) begin
      run_to(e);
      if (LED[2] !== 1'b0) bad2++;
      if ((LED & 4'b1011) !== (exp_led(e, 16, 4'hF) & 4'b1011)) bad_other++;
    end
    n_cmp++; if (bad2 != 0) begin n_bad++; $display("FAIL en_hold_low: got %0d high cycles expected 0", bad2); end
    n_cmp++; if (bad_other != 0) begin n_bad++; $display("FAIL en_hold_others: got %0d wrong cycles expected 0", bad_other); end
    EN = 4'hF;
    for (int e = 261; e <= 300; e++) begin
      run_to(e);
      exp = exp_led(e, 16, 4'hF);
      n_cmp++;
      if (LED !== exp) begin n_bad++; $display("FAIL en_resume_e%0d: got %b expected %b", e, LED, exp); end
    end
    $display("test_enable done");
  endtask

  task automatic test_reset_mid;
    run_to(305);
    n_cmp++; if (LED[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got %b expected 1", LED[0]); end
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (LED !== 4'h0) begin n_bad++; $display("FAIL rstmid_led: got %h expected 0", LED); end
    n_cmp++; if (DUTY !== 12'd0) begin n_bad++; $display("FAIL rstmid_duty: got %0d expected 0", DUTY); end
    n_cmp++; if (LEVEL !== 2'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d expected 0", LEVEL); end
    @(negedge CLK);
    RST = 1'b0;
    ecnt = 0;
    $display("test_reset_mid done");
  endtask

  task automatic test_hysteresis;
    LIGHT = 8'd125;
    run_to(201);
    n_cmp++; if (LEVEL !== 2'd0) begin n_bad++; $display("FAIL hyst_125: got %0d expected 0", LEVEL); end
    LIGHT = 8'd129;
    run_to(239);
    n_cmp++; if (LEVEL !== 2'd0) begin n_bad++; $display("FAIL hyst_129_pre: got %0d expected 0", LEVEL); end
    run_to(240);
    n_cmp++; if (LEVEL !== 2'd1) begin n_bad++; $display("FAIL hyst_129: got %0d expected 1", LEVEL); end
    n_cmp++; if (DUTY !== 12'd16) begin n_bad++; $display("FAIL hyst_old_target: got %0d expected 16", DUTY); end
    run_to(280);
    n_cmp++; if (DUTY !== 12'd12) begin n_bad++; $display("FAIL hyst_duty12: got %0d expected 12", DUTY); end
    run_to(320);
    n_cmp++; if (DUTY !== 12'd8) begin n_bad++; $display("FAIL hyst_duty8: got %0d expected 8", DUTY); end
    run_to(360);
    n_cmp++; if (DUTY !== 12'd8) begin n_bad++; $display("FAIL hyst_duty_hold: got %0d expected 8", DUTY); end
    LIGHT = 8'd115;
    run_to(400);
    n_cmp++; if (LEVEL !== 2'd1) begin n_bad++; $display("FAIL hyst_115: got %0d expected 1", LEVEL); end
    LIGHT = 8'd112;
    run_to(440);
    n_cmp++; if (LEVEL !== 2'd0) begin n_bad++; $display("FAIL hyst_112: got %0d expected 0", LEVEL); end
    n_cmp++; if (DUTY !== 12'd8) begin n_bad++; $display("FAIL hyst_dark_duty: got %0d expected 8", DUTY); end
    LIGHT = 8'd50;
    run_to(480);
    n_cmp++; if (DUTY !== 12'd12) begin n_bad++; $display("FAIL hyst_back12: got %0d expected 12", DUTY); end
    run_to(520);
    n_cmp++; if (DUTY !== 12'd16) begin n_bad++; $display("FAIL hyst_back16: got %0d expected 16", DUTY); end
    $display("test_hysteresis done");
  endtask

  task automatic test_bright;
    int exp_d [5];
    exp_d = '{12, 8, 4, 2, 2};
    LIGHT = 8'd200;
    run_to(560);
    n_cmp++; if (LEVEL !== 2'd2) begin n_bad++; $display("FAIL bright_level: got %0d expected 2", LEVEL); end
    n_cmp++; if (DUTY !== 12'd16) begin n_bad++; $display("FAIL bright_duty0: got %0d expected 16", DUTY); end
    for (int k = 0; k < 5; k++) begin
      run_to(600 + 40 * k);
      n_cmp++;
      if (DUTY !== 12'(exp_d[k])) begin
        n_bad++; $display("FAIL bright_duty%0d: got %0d expected %0d", k + 1, DUTY, exp_d[k]);
      end
    end
    $display("test_bright done");
  endtask

`ifdef LIGHT_PWM_MANUAL_EN
  task automatic test_manual;
    int exp_d [5];
    int bad;
    exp_d = '{6, 10, 14, 18, 20};
    MAN = 1'b1; MAN_DUTY = 12'd25;
    for (int k = 0; k < 5; k++) begin
      run_to(800 + 40 * k);
      n_cmp++;
      if (DUTY !== 12'(exp_d[k])) begin
        n_bad++; $display("FAIL man_duty%0d: got %0d expected %0d", k, DUTY, exp_d[k]);
      end
    end
    n_cmp++; if (LEVEL !== 2'd2) begin n_bad++; $display("FAIL man_level: got %0d expected 2", LEVEL); end
    bad = 0;
    for (int e = 961; e <= 1000; e++) begin
      run_to(e);
      if (LED !== 4'hF) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL man_led_high: got %0d low cycles expected 0", bad); end
    MAN = 1'b0;
    run_to(1040);
    n_cmp++; if (DUTY !== 12'd16) begin n_bad++; $display("FAIL man_release: got %0d expected 16", DUTY); end
    $display("test_manual done");
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_phase();
    test_enable();
    test_reset_mid();
    test_ramp_up();
    test_hysteresis();
    test_bright();
`ifdef LIGHT_PWM_MANUAL_EN
    test_manual();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/light_pwm_array.md
Name: light_pwm_array

Overview:
- Ambient-light-controlled LED PWM driver for N_CH channels, running on one system clock.
- Internal prescaler generates the PWM step tick and the light-sample tick (no separate 20 ms / 10 us clocks).
- Light level is classified with hysteresis into DARK/DIM/BRIGHT; duty ramps softly toward the level's target.
- Channel phases are staggered to spread LED current; sits between the light-sensor ADC interface and the headlamp/indicator LEDs.

Parameters:
- N_CH, 4, number of LED channels (1..16)
- LIGHT_W, 8, width of LIGHT input
- CNT_W, 12, width of PWM counter and duty values
- PERIOD, 2000, PWM period in step ticks; counter runs 0..PERIOD-1
- DIV_TICK, 500, CLK cycles per PWM step tick (>=1)
- SAMPLE_DIV, 2000, step ticks per light sample
- TH_LO, 120, DARK/DIM boundary
- TH_HI, 170, DIM/BRIGHT boundary
- HYST, 8, hysteresis band (LIGHT units)
- DUTY_DARK, 1600, target duty in DARK
- DUTY_DIM, 800, target duty in DIM
- DUTY_BRIGHT, 200, target duty in BRIGHT
- RAMP_STEP, 50, maximum duty change per PWM period

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- EN  in  N_CH  per-channel enable
- LIGHT  in  LIGHT_W  ambient light level (higher = brighter)
- LED  out  N_CH  PWM outputs
- LEVEL  out  2  current class: 0=DARK, 1=DIM, 2=BRIGHT
- DUTY  out  CNT_W  duty currently applied

Behaviour:
- Reset (async, RST=1):
  - LED=0, LEVEL=DARK, DUTY=0, target=DUTY_DARK.
  - Prescaler, PWM counter and sample counter cleared.
  - Asserting RST mid-period forces LED low in the same cycle.
  - After release, the counter restarts at 0 and the first sample occurs SAMPLE_DIV step ticks later.
- Tick generation:
  - Prescaler counts 0..DIV_TICK-1; step tick is a 1-cycle pulse when it wraps.
  - PWM counter advances on each step tick and wraps PERIOD-1 -> 0.
  - Period boundary = step tick on which the counter wraps to 0.
- Classifier FSM, evaluated only on sample ticks (LIGHT is ignored otherwise):
  - DARK -> DIM if LIGHT > TH_LO+HYST.
  - DIM -> DARK if LIGHT <= TH_LO-HYST.
  - DIM -> BRIGHT if LIGHT >= TH_HI+HYST.
  - BRIGHT -> DIM if LIGHT < TH_HI-HYST.
  - DARK -> BRIGHT directly if LIGHT >= TH_HI+HYST; BRIGHT -> DARK directly if LIGHT <= TH_LO-HYST.
  - Threshold arithmetic saturates at 0 and 2^LIGHT_W-1.
  - LEVEL updates 1 CLK after the sample tick; target is set from the new LEVEL.
- Ramp: at each period boundary, DUTY moves toward target by min(RAMP_STEP, |target-DUTY|). DUTY changes only at period boundaries, so no glitched pulses.
- Output, channel i:
  - Phase offset off_i = (PERIOD*i)/N_CH, constant.
  - ph_i = (counter + off_i) mod PERIOD, computed without overflow in CNT_W+1 bits.
  - LED[i] = EN[i] & (ph_i < DUTY), registered, 1 CLK latency from counter.
  - DUTY=0 -> constant low. DUTY>=PERIOD -> constant high.
- EN[i] deassert: LED[i] low on the next CLK. Reassert: resumes at the current phase, no restart.
- Simultaneous sample tick and period boundary: the ramp uses the target from before the sample; the new target applies from the next boundary.

Optional Feature:
- Macro LIGHT_PWM_MANUAL_EN.
- Defined:
  - Adds ports MAN (in, 1) and MAN_DUTY (in, CNT_W).
  - While MAN=1, target = MAN_DUTY clamped to PERIOD, and the ramp still applies.
  - The classifier keeps running and LEVEL stays valid.
- Undefined: ports absent; target comes only from LEVEL.

Decomposition:
- Package light_pkg:
  - level_t enum (DARK=0, DIM=1, BRIGHT=2).
  - Default thresholds, duty constants and the saturating add/sub functions.
- Sub-module light_level_fsm: hysteresis classifier (CLK, RST, sample tick, LIGHT -> LEVEL).
- Prescaler, ramp and comparators stay in the top module.

Test Plan (bench params: DIV_TICK=2, PERIOD=20, SAMPLE_DIV=20, N_CH=4, duties 16/8/2, RAMP_STEP=4):
- Reset mid-pulse, then release:
  - LED=0 in the same cycle; DUTY=0.
  - DUTY ramps 0,4,8,12,16 over 4 periods (LIGHT=50).
- LIGHT=50 steady, DUTY=16, EN=4'hF:
  - Each LED high 16 of every 20 step ticks.
  - Channel i rising edges offset by 5*i step ticks.
- LIGHT 125 then 129:
  - 125 stays DARK.
  - 129 -> DIM; DUTY ramps 16->12->8 and holds.
  - Then LIGHT=115 keeps DIM; 112 -> DARK.
- LIGHT jumps 50 -> 200:
  - DARK->BRIGHT in one sample.
  - DUTY 16,12,8,4,2 (last step clipped to 2).
- EN[2] dropped for 30 step ticks:
  - LED[2] low 1 CLK later while the other channels are unaffected.
  - On reassert, LED[2] matches the expected phase pattern.
- LIGHT_PWM_MANUAL_EN, MAN=1, MAN_DUTY=25:
  - DUTY ramps to 20 (clamped); all enabled LEDs constantly high.
  - MAN=0 ramps DUTY back toward the LEVEL target.
